ysyx_041461_if_pc_gen: RTL and testbench
========================================

// Module: ysyx_041461_if_pc_gen
// PURPOSE
//   Instruction-fetch stage front end: owns the architectural PC and issues one fetch at a time to instruction memory.
//   Presents {pc, inst} to ID via a valid/ready handshake.
//   Consumes trap/return redirects produced by the write-back stage (ctrl/mtvec/mepc/cause) and branch redirects from EXE.
//   Returns IF_ok to write-back so a trap only commits when no fetch is outstanding.
// PARAMETERS
//   RESET_PC   64'h8000_0000   PC loaded on reset
//   NOP_INST   32'h0000_0013   instruction word presented with a misaligned-PC trap
// PORTS
//   clk              in   1   clock; all state updates on posedge
//   rst              in   1   synchronous, active-high reset
//   IF_redirect_ctrl in   2   from WB: 2'd0 NOP, 2'd1 MTVEC, 2'd2 MEPC, 2'd3 reserved (treated as NOP)
//   IF_mtvec         in  64   mtvec CSR value
//   IF_mepc          in  64   mepc CSR value
//   IF_cause         in  63   trap cause code; nonzero only for interrupts
//   IF_br_taken      in   1   EXE branch/jump redirect strobe
//   IF_br_target     in  64   EXE redirect target
//   IF_ID_ready      in   1   ID accepts the presented instruction this cycle
//   IF_ID_valid      out  1   instruction/pc valid toward ID
//   IF_ID_pc         out 64   pc of the presented instruction
//   IF_ID_inst       out 32   fetched instruction word
//   IF_ID_misalign   out  1   presented pc has pc[1:0]!=0; inst is NOP_INST
//   IF_ok            out  1   1 when no imem transaction is outstanding (state != WAIT)
//   imem_req         out  1   fetch request
//   imem_addr        out 64   fetch address; equals pc while imem_req=1
//   imem_gnt         in   1   request accepted this cycle
//   imem_rvalid      in   1   read data returned, at least 1 cycle after gnt
//   imem_rdata       in  32   returned instruction word
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=REQ, drop=0; IF_ID_valid=0, IF_ID_pc=0, IF_ID_inst=0, IF_ID_misalign=0, imem_req=0 in the reset cycle, IF_ok=1.
//   Redirect target priority: WB ctrl MTVEC > WB ctrl MEPC > IF_br_taken > sequential pc+4.
//     MTVEC -> {mtvec[63:2],2'b00}; MEPC -> mepc.
//     A redirect in any state loads pc in the same cycle.
//   States:
//     REQ:
//       - If pc[1:0]!=0: no request. Present valid=1, misalign=1, inst=NOP_INST -> TRAP.
//       - Else imem_req=1, addr=pc. gnt -> WAIT.
//       - Redirect without gnt: stay in REQ; the new pc is driven next cycle.
//       - Redirect with gnt: -> WAIT with drop=1 (the old fetch is in flight).
//     WAIT (IF_ok=0):
//       - rvalid && !drop: latch inst/pc, IF_ID_valid=1 next cycle -> HOLD.
//       - rvalid && drop: discard the data, clear drop -> REQ.
//       - Redirect while waiting: set drop=1.
//     HOLD:
//       - Outputs stable while !IF_ID_ready.
//       - IF_ID_ready with no redirect: pc+=4, valid=0 -> REQ.
//       - Redirect: valid=0 next cycle, discard -> REQ.
//     TRAP:
//       - Misaligned entry, presented until accepted, then valid=0.
//       - Stays idle (no fetch) until any redirect -> REQ.
//   Latency: REQ with gnt in cycle n, rvalid in n+1 -> IF_ID_valid in n+2. One outstanding fetch maximum.
//   Simultaneous WB redirect and IF_br_taken: WB wins; the branch is ignored.
//   rvalid in any state other than WAIT is ignored. imem_rdata is sampled only on rvalid in WAIT.
//   pc+4 arithmetic is 64-bit wrap-around (64'hFFFF_FFFF_FFFF_FFFC+4 = 0).
//   Reset mid-transaction: all state returns to reset values. A late rvalid after reset is ignored (state != WAIT).
// CONFIGURATION
//   YSYX_041461_MTVEC_VECTOR_EN
//     Defined: when mtvec[1:0]==2'b01 and IF_cause!=0, MTVEC target = {mtvec[63:2],2'b00} + (IF_cause<<2).
//       Any other mtvec mode or cause uses the base address.
//     Undefined: MTVEC target is always {mtvec[63:2],2'b00}; IF_cause is unused.
// TESTING
//   1. Reset, gnt immediate, rvalid 1 cycle later, rdata=32'h00100093, ready=1
//      -> valid with pc=8000_0000, next fetch addr 8000_0004.
//   2. HOLD with ready=0 for 5 cycles -> pc/inst/valid stable, imem_req=0; ready=1 -> pc advances to +4.
//   3. Redirect MTVEC (mtvec=8000_1001) while in WAIT -> IF_ok=0 until rvalid, data dropped, next imem_addr=8000_1000.
//      With _EN and cause=7: imem_addr=8000_101C.
//   4. Same cycle: WB ctrl MEPC (mepc=8000_0200) and br_taken (target 8000_0300) -> next imem_addr=8000_0200.
//   5. Branch to 8000_0102 -> no imem_req; valid=1, misalign=1, inst=0000_0013; stays idle until MTVEC redirect.
//   6. Assert rst during WAIT, then deliver rvalid -> outputs at reset values, data ignored, first fetch at 8000_0000.

Source files
------------

// File: rtl/ysyx_041461_if_pc_gen.sv
// IF-stage PC generator: owns the PC, issues one imem fetch at a time, presents {pc, inst} to ID.
// Optional vectored-mtvec trap targets are enabled by defining YSYX_041461_MTVEC_VECTOR_EN.
module ysyx_041461_if_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  IF_redirect_ctrl,
  input  logic [63:0] IF_mtvec,
  input  logic [63:0] IF_mepc,
  input  logic [62:0] IF_cause,
  input  logic        IF_br_taken,
  input  logic [63:0] IF_br_target,
  input  logic        IF_ID_ready,
  output logic        IF_ID_valid,
  output logic [63:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_misalign,
  output logic        IF_ok,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        drop;

  logic        wb_mtvec;
  logic        wb_mepc;
  logic        redirect;
  logic [63:0] mtvec_base;
  logic [63:0] mtvec_target;
  logic [63:0] redirect_pc;
  logic        pc_aligned;
  logic        unused_c;

  // Redirect target: WB MTVEC > WB MEPC > EXE branch; ctrl 2'd3 behaves as NOP
  always_comb begin
    wb_mtvec    = (IF_redirect_ctrl == 2'd1);
    wb_mepc     = (IF_redirect_ctrl == 2'd2);
    redirect    = wb_mtvec | wb_mepc | IF_br_taken;
    mtvec_base  = {IF_mtvec[63:2], 2'b00};
`ifdef YSYX_041461_MTVEC_VECTOR_EN
    if ((IF_mtvec[1:0] == 2'b01) && (IF_cause != '0))
      mtvec_target = mtvec_base + {IF_cause[61:0], 2'b00};
    else
      mtvec_target = mtvec_base;
    unused_c     = IF_cause[62];
`else
    mtvec_target = mtvec_base;
    unused_c     = ^{IF_cause, IF_mtvec[1:0]};
`endif
    if (wb_mtvec)
      redirect_pc = mtvec_target;
    else if (wb_mepc)
      redirect_pc = IF_mepc;
    else
      redirect_pc = IF_br_target;
    pc_aligned  = (pc[1:0] == 2'b00);
  end

  assign imem_req  = !rst && (state == S_REQ) && pc_aligned;
  assign imem_addr = pc;
  assign IF_ok     = rst || (state != S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      IF_ID_valid    <= 1'b0;
      IF_ID_pc       <= 64'd0;
      IF_ID_inst     <= 32'd0;
      IF_ID_misalign <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
            // The granted fetch of the old pc is still in flight and must be discarded
            if (pc_aligned && imem_gnt) begin
              state <= S_WAIT;
              drop  <= 1'b1;
            end
          end else if (!pc_aligned) begin
            IF_ID_valid    <= 1'b1;
            IF_ID_pc       <= pc;
            IF_ID_inst     <= NOP_INST;
            IF_ID_misalign <= 1'b1;
            state          <= S_TRAP;
          end else if (imem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) pc <= redirect_pc;
          if (imem_rvalid) begin
            if (drop || redirect) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              IF_ID_valid    <= 1'b1;
              IF_ID_pc       <= pc;
              IF_ID_inst     <= imem_rdata;
              IF_ID_misalign <= 1'b0;
              state          <= S_HOLD;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc          <= redirect_pc;
            IF_ID_valid <= 1'b0;
            state       <= S_REQ;
          end else if (IF_ID_ready) begin
            pc          <= pc + 64'd4;
            IF_ID_valid <= 1'b0;
            state       <= S_REQ;
          end
        end
        S_TRAP: begin
          if (IF_ID_ready) begin
            IF_ID_valid    <= 1'b0;
            IF_ID_misalign <= 1'b0;
          end
          // Idle until WB or EXE steers the pc somewhere legal
          if (redirect) begin
            pc             <= redirect_pc;
            IF_ID_valid    <= 1'b0;
            IF_ID_misalign <= 1'b0;
            state          <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_if_pc_gen.sv
// Scoreboard bench for ysyx_041461_if_pc_gen: expected {pc, inst, misalign} queued at fetch grant,
// compared when ID accepts the presented instruction.
module tb_ysyx_041461_if_pc_gen;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef YSYX_041461_MTVEC_VECTOR_EN
  localparam logic [63:0] MTV_EXP = 64'h8000_101C;
`else
  localparam logic [63:0] MTV_EXP = 64'h8000_1000;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  ctrl;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic [62:0] cause;
  logic        br_taken;
  logic [63:0] br_target;
  logic        ready;
  logic        valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        misalign;
  logic        if_ok;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  ysyx_041461_if_pc_gen #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst),
    .IF_redirect_ctrl(ctrl), .IF_mtvec(mtvec), .IF_mepc(mepc), .IF_cause(cause),
    .IF_br_taken(br_taken), .IF_br_target(br_target),
    .IF_ID_ready(ready), .IF_ID_valid(valid), .IF_ID_pc(id_pc), .IF_ID_inst(id_inst),
    .IF_ID_misalign(misalign), .IF_ok(if_ok),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sb_pop();
    exp_t e;
    e = '1;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1; ctrl = 2'd0; mtvec = '0; mepc = '0; cause = '0; br_taken = 1'b0;
    br_target = '0; ready = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    tick; tick;
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign, imem_req, if_ok} !== {1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b pc=%h inst=%h mis=%b req=%b ok=%b want 0/0/0/0/0/1",
               valid, id_pc, id_inst, misalign, imem_req, if_ok);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      n_bad++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_basic_fetch;
    exp_t e;
    gnt = 1'b1; sb.push_back({RESET_PC, 32'h0010_0093, 1'b0});
    tick; gnt = 1'b0;
    n_cmp++;
    if ({if_ok, imem_req} !== 2'b00) begin
      n_bad++; $display("FAIL basic_wait: got ok=%b req=%b want 0/0", if_ok, imem_req);
    end
    rvalid = 1'b1; rdata = 32'h0010_0093;
    tick; rvalid = 1'b0; rdata = '0;
    ready = 1'b1; e = sb_pop();
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign} !== {1'b1, e}) begin
      n_bad++; $display("FAIL basic_present: got v=%b pc=%h inst=%h mis=%b want 1/%h/%h/%b",
                        valid, id_pc, id_inst, misalign, e.pc, e.inst, e.mis);
    end
    tick; ready = 1'b0;
    n_cmp++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h8000_0004}) begin
      n_bad++; $display("FAIL basic_next: got v=%b req=%b addr=%h want 0/1/80000004", valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_hold_stall;
    exp_t e;
    gnt = 1'b1; sb.push_back({64'h8000_0004, 32'h0020_8113, 1'b0});
    tick; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0020_8113;
    tick; rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({valid, id_pc, id_inst, imem_req} !== {1'b1, 64'h8000_0004, 32'h0020_8113, 1'b0}) begin
        n_bad++; $display("FAIL hold_stable[%0d]: got v=%b pc=%h inst=%h req=%b want 1/80000004/00208113/0",
                          i, valid, id_pc, id_inst, imem_req);
      end
      tick;
    end
    ready = 1'b1; e = sb_pop();
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign} !== {1'b1, e}) begin
      n_bad++; $display("FAIL hold_accept: got pc=%h inst=%h want %h/%h", id_pc, id_inst, e.pc, e.inst);
    end
    tick; ready = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h8000_0008}) begin
      n_bad++; $display("FAIL hold_next: got req=%b addr=%h want 1/80000008", imem_req, imem_addr);
    end
  endtask

  task automatic test_mtvec_redirect;
    exp_t e;
    gnt = 1'b1;
    tick; gnt = 1'b0;
    ctrl = 2'd1; mtvec = 64'h8000_1001; cause = 63'd7;
    tick; ctrl = 2'd0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({if_ok, imem_req} !== 2'b00) begin
        n_bad++; $display("FAIL mtvec_wait[%0d]: got ok=%b req=%b want 0/0", i, if_ok, imem_req);
      end
      tick;
    end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick; rvalid = 1'b0;
    n_cmp++;
    if ({if_ok, valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, MTV_EXP}) begin
      n_bad++; $display("FAIL mtvec_target: got ok=%b v=%b req=%b addr=%h want 1/0/1/%h",
                        if_ok, valid, imem_req, imem_addr, MTV_EXP);
    end
    gnt = 1'b1; sb.push_back({MTV_EXP, 32'h1111_1111, 1'b0});
    tick; gnt = 1'b0;
    tick; rvalid = 1'b1; rdata = 32'h1111_1111;
    tick; rvalid = 1'b0;
    ready = 1'b1; e = sb_pop();
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign} !== {1'b1, e}) begin
      n_bad++; $display("FAIL mtvec_fetch: got v=%b pc=%h inst=%h want 1/%h/%h", valid, id_pc, id_inst, e.pc, e.inst);
    end
    tick; ready = 1'b0;
  endtask

  task automatic test_mepc_vs_branch;
    ctrl = 2'd3;
    tick; ctrl = 2'd0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, MTV_EXP + 64'd4}) begin
      n_bad++; $display("FAIL ctrl_reserved: got req=%b addr=%h want 1/%h", imem_req, imem_addr, MTV_EXP + 64'd4);
    end
    ctrl = 2'd2; mepc = 64'h8000_0200; br_taken = 1'b1; br_target = 64'h8000_0300;
    tick; ctrl = 2'd0; br_taken = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h8000_0200}) begin
      n_bad++; $display("FAIL mepc_priority: got req=%b addr=%h want 1/80000200", imem_req, imem_addr);
    end
    br_taken = 1'b1; br_target = 64'h8000_0400; gnt = 1'b1;
    tick; br_taken = 1'b0; gnt = 1'b0;
    n_cmp++;
    if (if_ok !== 1'b0) begin
      n_bad++; $display("FAIL redirect_gnt_wait: got ok=%b want 0", if_ok);
    end
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    tick; rvalid = 1'b0;
    n_cmp++;
    if ({if_ok, valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 64'h8000_0400}) begin
      n_bad++; $display("FAIL redirect_gnt_drop: got ok=%b v=%b req=%b addr=%h want 1/0/1/80000400",
                        if_ok, valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_misalign_trap;
    exp_t e;
    br_taken = 1'b1; br_target = 64'h8000_0102;
    tick; br_taken = 1'b0;
    n_cmp++;
    if ({imem_req, if_ok, valid} !== 3'b010) begin
      n_bad++; $display("FAIL misalign_noreq: got req=%b ok=%b v=%b want 0/1/0", imem_req, if_ok, valid);
    end
    sb.push_back({64'h8000_0102, NOP_INST, 1'b1});
    tick;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({valid, id_pc, id_inst, misalign, imem_req} !== {1'b1, 64'h8000_0102, NOP_INST, 1'b1, 1'b0}) begin
        n_bad++; $display("FAIL trap_present[%0d]: got v=%b pc=%h inst=%h mis=%b req=%b want 1/80000102/00000013/1/0",
                          i, valid, id_pc, id_inst, misalign, imem_req);
      end
      tick;
    end
    ready = 1'b1; e = sb_pop();
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign} !== {1'b1, e}) begin
      n_bad++; $display("FAIL trap_accept: got pc=%h inst=%h mis=%b want %h/%h/%b", id_pc, id_inst, misalign, e.pc, e.inst, e.mis);
    end
    tick; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = (i == 1);
      n_cmp++;
      if ({valid, imem_req} !== 2'b00) begin
        n_bad++; $display("FAIL trap_idle[%0d]: got v=%b req=%b want 0/0", i, valid, imem_req);
      end
      tick;
    end
    rvalid = 1'b0;
    ctrl = 2'd1; mtvec = 64'h8000_1000; cause = 63'd7;
    tick; ctrl = 2'd0;
    n_cmp++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h8000_1000}) begin
      n_bad++; $display("FAIL trap_exit: got v=%b req=%b addr=%h want 0/1/80001000", valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_pc_wrap;
    exp_t e;
    br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick; br_taken = 1'b0;
    gnt = 1'b1; sb.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0073, 1'b0});
    tick; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0073;
    tick; rvalid = 1'b0;
    ready = 1'b1; e = sb_pop();
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign} !== {1'b1, e}) begin
      n_bad++; $display("FAIL wrap_present: got pc=%h inst=%h want %h/%h", id_pc, id_inst, e.pc, e.inst);
    end
    tick; ready = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 64'd0}) begin
      n_bad++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    logic [63:0] exp_addr;
    logic [31:0] d;
    int          k;
    exp_addr = 64'd0;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      k = 0;
      while (!imem_req && k < 4) begin tick; k++; end
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
        n_bad++; $display("FAIL b2b_req[%0d]: got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, exp_addr);
      end
      d = $urandom;
      gnt = 1'b1; sb.push_back({exp_addr, d, 1'b0});
      tick; gnt = 1'b0;
      for (int j = 0; j < i % 3; j++) tick;
      rvalid = 1'b1; rdata = d;
      tick; rvalid = 1'b0;
      e = sb_pop();
      n_cmp++;
      if ({valid, id_pc, id_inst, misalign} !== {1'b1, e}) begin
        n_bad++; $display("FAIL b2b_data[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h", i, valid, id_pc, id_inst, e.pc, e.inst);
      end
      tick;
      exp_addr = exp_addr + 64'd4;
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    exp_t e;
    gnt = 1'b1;
    tick; gnt = 1'b0;
    n_cmp++;
    if (if_ok !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_wait: got ok=%b want 0", if_ok);
    end
    rst = 1'b1;
    tick;
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign, imem_req, if_ok} !== {1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL rstmid_outputs: got v=%b pc=%h inst=%h mis=%b req=%b ok=%b want 0/0/0/0/0/1",
                        valid, id_pc, id_inst, misalign, imem_req, if_ok);
    end
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick; rvalid = 1'b0;
    n_cmp++;
    if ({valid, imem_req, imem_addr, if_ok} !== {1'b0, 1'b1, RESET_PC, 1'b1}) begin
      n_bad++; $display("FAIL rstmid_late_rvalid: got v=%b req=%b addr=%h ok=%b want 0/1/%h/1",
                        valid, imem_req, imem_addr, if_ok, RESET_PC);
    end
    gnt = 1'b1; sb.push_back({RESET_PC, 32'h0000_0513, 1'b0});
    tick; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0513;
    tick; rvalid = 1'b0;
    ready = 1'b1; e = sb_pop();
    n_cmp++;
    if ({valid, id_pc, id_inst, misalign} !== {1'b1, e}) begin
      n_bad++; $display("FAIL rstmid_refetch: got v=%b pc=%h inst=%h want 1/%h/%h", valid, id_pc, id_inst, e.pc, e.inst);
    end
    tick; ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_mtvec_redirect();
    test_mepc_vs_branch();
    test_misalign_trap();
    test_pc_wrap();
    test_back_to_back();
    test_reset_mid_wait();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
